// File: rtl/ws2812b_serializer_if.sv
// Pixel-stream handshake between the register block and the WS2812B serializer.
// Build option: WS2812B_RGBW_EN widens the pixel word from 24-bit GRB to 32-bit GRBW.
interface ws2812b_serializer_if;
`ifdef WS2812B_RGBW_EN
    localparam int PW = 32;
`else
    localparam int PW = 24;
`endif

    logic [PW-1:0] pixel_data;
    logic          pixel_last;
    logic          pixel_valid;
    logic          pixel_ready;

    modport master (
        output pixel_data,
        output pixel_last,
        output pixel_valid,
        input  pixel_ready
    );

    modport slave (
        input  pixel_data,
        input  pixel_last,
        input  pixel_valid,
        output pixel_ready
    );
endinterface

// File: rtl/ws2812b_serializer.sv
// Serialises GRB(W) pixel words MSB-first onto a WS2812B NRZ data line, with a one-pixel holding register.
// Build option: WS2812B_RGBW_EN selects 32-bit GRBW pixels instead of 24-bit GRB.
module ws2812b_serializer #(
    parameter int BIT_CYCLES   = 125,
    parameter int T0H_CYCLES   = 40,
    parameter int T1H_CYCLES   = 80,
    parameter int RESET_CYCLES = 8000
) (
    input  logic                       ACLK,
    input  logic                       ARESETN,
    ws2812b_serializer_if.slave        pixel,
    output logic                       dout,
    output logic                       busy,
    output logic                       frame_done,
    output logic                       underrun
);

`ifdef WS2812B_RGBW_EN
    localparam int PW = 32;
`else
    localparam int PW = 24;
`endif

    localparam int MAXC = (BIT_CYCLES > RESET_CYCLES) ? BIT_CYCLES : RESET_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    localparam int IW   = $clog2(PW);

    // Counters are loaded with (duration - 1) and run down to zero.
    localparam logic [CW-1:0] T0H_M1   = CW'(T0H_CYCLES - 1);
    localparam logic [CW-1:0] T1H_M1   = CW'(T1H_CYCLES - 1);
    localparam logic [CW-1:0] T0L_M1   = CW'(BIT_CYCLES - T0H_CYCLES - 1);
    localparam logic [CW-1:0] T1L_M1   = CW'(BIT_CYCLES - T1H_CYCLES - 1);
    localparam logic [CW-1:0] RESET_M1 = CW'(RESET_CYCLES - 1);
    localparam logic [IW-1:0] TOP_IDX  = IW'(PW - 1);

    if (!(T0H_CYCLES > 0 && T0H_CYCLES < T1H_CYCLES && T1H_CYCLES < BIT_CYCLES)) begin : g_bad_timing
        $error("ws2812b_serializer: require 0 < T0H_CYCLES < T1H_CYCLES < BIT_CYCLES");
    end

    typedef enum logic [1:0] {IDLE, HIGH, LOW, LATCH} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [PW-1:0] shreg;
    logic [IW-1:0] bit_idx;
    logic          cur_last;
    logic [PW-1:0] hold_data;
    logic          hold_last;
    logic          hold_full;
    logic          accept;
    logic          load;
    logic [CW-1:0] th_hold;
    logic [CW-1:0] th_next;

    assign pixel.pixel_ready = !hold_full;
    assign accept            = pixel.pixel_valid && !hold_full;
    assign busy              = (state != IDLE) || hold_full;
    assign th_hold           = hold_data[PW-1] ? T1H_M1 : T0H_M1;
    assign th_next           = shreg[PW-2]     ? T1H_M1 : T0H_M1;

    // A held pixel moves into the shifter from IDLE, or at the end of the final bit of a non-last pixel.
    always_comb begin
        load = 1'b0;
        case (state)
            IDLE:    load = hold_full;
            LOW:     load = hold_full && (cnt == '0) && (bit_idx == '0) && !cur_last;
            default: load = 1'b0;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state      <= IDLE;
            cnt        <= '0;
            shreg      <= '0;
            bit_idx    <= '0;
            cur_last   <= 1'b0;
            hold_data  <= '0;
            hold_last  <= 1'b0;
            hold_full  <= 1'b0;
            dout       <= 1'b0;
            frame_done <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            underrun   <= 1'b0;
            if (accept) begin
                hold_data <= pixel.pixel_data;
                hold_last <= pixel.pixel_last;
            end
            hold_full <= accept || (hold_full && !load);

            if (load) begin
                shreg    <= hold_data;
                cur_last <= hold_last;
                bit_idx  <= TOP_IDX;
                cnt      <= th_hold;
                dout     <= 1'b1;
                state    <= HIGH;
            end else begin
                case (state)
                    HIGH: begin
                        if (cnt == '0) begin
                            dout  <= 1'b0;
                            cnt   <= shreg[PW-1] ? T1L_M1 : T0L_M1;
                            state <= LOW;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                    LOW: begin
                        if (cnt != '0) begin
                            cnt <= cnt - 1'b1;
                        end else if (bit_idx != '0) begin
                            shreg   <= shreg << 1;
                            bit_idx <= bit_idx - 1'b1;
                            cnt     <= th_next;
                            dout    <= 1'b1;
                            state   <= HIGH;
                        end else begin
                            underrun <= !cur_last;
                            cnt      <= RESET_M1;
                            state    <= LATCH;
                        end
                    end
                    LATCH: begin
                        if (cnt == '0) begin
                            frame_done <= 1'b1;
                            state      <= IDLE;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ws2812b_serializer.sv
// Randomised and directed checks of ws2812b_serializer against a bit-period waveform model.
// Honours WS2812B_RGBW_EN to match the DUT pixel width.
module tb_ws2812b_serializer;
`ifdef WS2812B_RGBW_EN
    localparam int PW = 32;
`else
    localparam int PW = 24;
`endif
    localparam int BIT   = 125;
    localparam int T0H   = 40;
    localparam int T1H   = 80;
    localparam int RST   = 8000;
    localparam int LOG_N = 100000;

    logic ACLK = 1'b0;
    logic ARESETN = 1'b0;
    logic dout, busy, frame_done, underrun;

    ws2812b_serializer_if bus ();

    ws2812b_serializer #(
        .BIT_CYCLES  (BIT),
        .T0H_CYCLES  (T0H),
        .T1H_CYCLES  (T1H),
        .RESET_CYCLES(RST)
    ) dut (
        .ACLK      (ACLK),
        .ARESETN   (ARESETN),
        .pixel     (bus),
        .dout      (dout),
        .busy      (busy),
        .frame_done(frame_done),
        .underrun  (underrun)
    );

    always #5 ACLK = ~ACLK;

    int nvec = 0;
    int nfail = 0;
    int cyc = 0;
    bit log_dout[LOG_N];
    bit log_fd[LOG_N];
    bit log_ur[LOG_N];
    bit log_busy[LOG_N];
    bit log_rdy[LOG_N];
    logic [PW-1:0] pix_q[$];
    int exp_h[$];

    // Sample index n holds the outputs seen after the n-th rising edge.
    always @(negedge ACLK) begin
        if (cyc < LOG_N) begin
            log_dout[cyc] <= dout;
            log_fd[cyc]   <= frame_done;
            log_ur[cyc]   <= underrun;
            log_busy[cyc] <= busy;
            log_rdy[cyc]  <= bus.pixel_ready;
            cyc           <= cyc + 1;
        end
    end

    // Reference: every bit is one BIT-long slot, high for T1H ('1') or T0H ('0'), MSB first, pixels contiguous.
    function automatic void model_bits();
        exp_h = {};
        foreach (pix_q[i]) begin
            logic [PW-1:0] p;
            p = pix_q[i];
            for (int b = PW - 1; b >= 0; b--) exp_h.push_back(p[b] ? T1H : T0H);
        end
    endfunction

    function automatic int seg_high(input int s);
        int k;
        if (s < 0 || s + BIT > LOG_N) return -2;
        k = 0;
        while (k < BIT && log_dout[s+k]) k++;
        for (int j = k; j < BIT; j++) if (log_dout[s+j]) return -1;
        return k;
    endfunction

    function automatic int ones_in(input int s, input int n);
        int c;
        c = 0;
        for (int i = s; i < s + n; i++) if (i >= 0 && i < LOG_N && log_dout[i]) c++;
        return c;
    endfunction

    function automatic int find_rise(input int s, input int n);
        for (int i = s; i < s + n; i++) if (i >= 0 && i < LOG_N && log_dout[i]) return i;
        return -1;
    endfunction

    function automatic int find_pulse(input bit is_fd, input int s, input int n, output int cnt);
        int first;
        first = -1;
        cnt = 0;
        for (int i = s; i < s + n; i++) begin
            if (i >= 0 && i < LOG_N && (is_fd ? log_fd[i] : log_ur[i])) begin
                if (first < 0) first = i;
                cnt++;
            end
        end
        return first;
    endfunction

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge ACLK);
        #1;
    endtask

    // Offers one pixel; hs returns the sample index reflecting the accepting edge.
    task automatic push(input logic [PW-1:0] d, input bit last, output int hs);
        bit r;
        hs = -1;
        bus.pixel_data  = d;
        bus.pixel_last  = last;
        bus.pixel_valid = 1'b1;
        for (int i = 0; i < 20000 && hs < 0; i++) begin
            r = bus.pixel_ready;
            @(posedge ACLK);
            #1;
            if (r) hs = cyc;
        end
        bus.pixel_valid = 1'b0;
        bus.pixel_last  = 1'b0;
        bus.pixel_data  = PW'($urandom);
        if (hs < 0) begin
            nvec++;
            nfail++;
            $display("FAIL push_timeout: accepted=0 required=1");
        end
    endtask

    task automatic test_reset();
        ARESETN = 1'b0;
        wait_cycles(3);
        nvec++; if (dout !== 1'b0)            begin nfail++; $display("FAIL reset_dout: got %b want 0", dout); end
        nvec++; if (bus.pixel_ready !== 1'b1) begin nfail++; $display("FAIL reset_ready: got %b want 1", bus.pixel_ready); end
        nvec++; if (busy !== 1'b0)            begin nfail++; $display("FAIL reset_busy: got %b want 0", busy); end
        nvec++; if (frame_done !== 1'b0)      begin nfail++; $display("FAIL reset_frame_done: got %b want 0", frame_done); end
        nvec++; if (underrun !== 1'b0)        begin nfail++; $display("FAIL reset_underrun: got %b want 0", underrun); end
        ARESETN = 1'b1;
        wait_cycles(3);
        nvec++; if (busy !== 1'b0 || dout !== 1'b0) begin nfail++; $display("FAIL idle_after_reset: busy=%b dout=%b want 0 0", busy, dout); end
    endtask

    task automatic test_single();
        logic [31:0] v;
        int hs, rise, base, fdi, fdc, urc, obs;
`ifdef WS2812B_RGBW_EN
        v = 32'h8000_0001;
`else
        v = 32'h00FF_0000;
`endif
        pix_q = {};
        pix_q.push_back(v[PW-1:0]);
        model_bits();
        push(pix_q[0], 1'b1, hs);
        wait_cycles(PW * BIT + RST + 50);
        rise = find_rise(hs, 100);
        nvec++; if (rise !== hs + 1) begin nfail++; $display("FAIL single_latency: rise=%0d want %0d", rise, hs + 1); end
        for (int k = 0; k < exp_h.size(); k++) begin
            obs = seg_high(rise + k * BIT);
            nvec++; if (obs !== exp_h[k]) begin nfail++; $display("FAIL single_bit%0d: high=%0d want %0d", k, obs, exp_h[k]); end
        end
        base = rise + exp_h.size() * BIT;
        nvec++; if (ones_in(base, RST) !== 0) begin nfail++; $display("FAIL single_latch_low: ones=%0d want 0", ones_in(base, RST)); end
        fdi = find_pulse(1'b1, hs, base + RST + 40 - hs, fdc);
        nvec++; if (fdc !== 1 || fdi !== base + RST) begin nfail++; $display("FAIL single_frame_done: at=%0d count=%0d want at=%0d count=1", fdi, fdc, base + RST); end
        void'(find_pulse(1'b0, hs, base + RST + 40 - hs, urc));
        nvec++; if (urc !== 0) begin nfail++; $display("FAIL single_underrun: count=%0d want 0", urc); end
        nvec++; if (log_busy[base+RST-1] !== 1'b1 || log_busy[base+RST] !== 1'b0) begin
            nfail++; $display("FAIL single_busy_end: before=%b after=%b want 1 0", log_busy[base+RST-1], log_busy[base+RST]);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a, b;
        int hs1, hs2, rise, base, fdi, fdc, urc, obs;
        a = 32'hAAAA_AAAA;
        b = 32'h5555_5555;
        pix_q = {};
        pix_q.push_back(a[PW-1:0]);
        pix_q.push_back(b[PW-1:0]);
        model_bits();
        push(pix_q[0], 1'b0, hs1);
        push(pix_q[1], 1'b1, hs2);
        nvec++; if (hs2 !== hs1 + 2) begin nfail++; $display("FAIL b2b_second_accept: at=%0d want %0d", hs2, hs1 + 2); end
        wait_cycles(2 * PW * BIT + RST + 50);
        rise = find_rise(hs1, 100);
        nvec++; if (rise !== hs1 + 1) begin nfail++; $display("FAIL b2b_latency: rise=%0d want %0d", rise, hs1 + 1); end
        for (int k = 0; k < exp_h.size(); k++) begin
            obs = seg_high(rise + k * BIT);
            nvec++; if (obs !== exp_h[k]) begin nfail++; $display("FAIL b2b_bit%0d: high=%0d want %0d", k, obs, exp_h[k]); end
        end
        base = rise + exp_h.size() * BIT;
        nvec++; if (ones_in(base, RST) !== 0) begin nfail++; $display("FAIL b2b_latch_low: ones=%0d want 0", ones_in(base, RST)); end
        fdi = find_pulse(1'b1, hs1, base + RST + 40 - hs1, fdc);
        nvec++; if (fdc !== 1 || fdi !== base + RST) begin nfail++; $display("FAIL b2b_frame_done: at=%0d count=%0d want at=%0d count=1", fdi, fdc, base + RST); end
        void'(find_pulse(1'b0, hs1, base + RST + 40 - hs1, urc));
        nvec++; if (urc !== 0) begin nfail++; $display("FAIL b2b_underrun: count=%0d want 0", urc); end
    endtask

    task automatic test_underrun();
        logic [31:0] v;
        int hs, rise, base, fdi, fdc, uri, urc, obs;
        v = 32'h0000_0001;
        pix_q = {};
        pix_q.push_back(v[PW-1:0]);
        model_bits();
        push(pix_q[0], 1'b0, hs);
        wait_cycles(PW * BIT + RST + 50);
        rise = find_rise(hs, 100);
        nvec++; if (rise !== hs + 1) begin nfail++; $display("FAIL ur_latency: rise=%0d want %0d", rise, hs + 1); end
        for (int k = 0; k < exp_h.size(); k++) begin
            obs = seg_high(rise + k * BIT);
            nvec++; if (obs !== exp_h[k]) begin nfail++; $display("FAIL ur_bit%0d: high=%0d want %0d", k, obs, exp_h[k]); end
        end
        base = rise + exp_h.size() * BIT;
        uri = find_pulse(1'b0, hs, base + RST + 40 - hs, urc);
        nvec++; if (urc !== 1 || uri !== base) begin nfail++; $display("FAIL ur_pulse: at=%0d count=%0d want at=%0d count=1", uri, urc, base); end
        nvec++; if (ones_in(base, RST) !== 0) begin nfail++; $display("FAIL ur_latch_low: ones=%0d want 0", ones_in(base, RST)); end
        fdi = find_pulse(1'b1, hs, base + RST + 40 - hs, fdc);
        nvec++; if (fdc !== 1 || fdi !== base + RST) begin nfail++; $display("FAIL ur_frame_done: at=%0d count=%0d want at=%0d count=1", fdi, fdc, base + RST); end
    endtask

    task automatic test_backpressure();
        int hs[3];
        int rise, base, fdi, fdc, urc, obs, ld2;
        pix_q = {};
        for (int i = 0; i < 3; i++) pix_q.push_back(PW'($urandom));
        model_bits();
        for (int i = 0; i < 3; i++) push(pix_q[i], i == 2, hs[i]);
        wait_cycles(2 * PW * BIT + RST + 50);
        rise = find_rise(hs[0], 100);
        ld2  = rise + PW * BIT;
        nvec++; if (hs[1] !== hs[0] + 2) begin nfail++; $display("FAIL bp_accept2: at=%0d want %0d", hs[1], hs[0] + 2); end
        nvec++; if (hs[2] !== ld2 + 1) begin nfail++; $display("FAIL bp_accept3: at=%0d want %0d", hs[2], ld2 + 1); end
        nvec++; if (log_rdy[ld2-1] !== 1'b0 || log_rdy[ld2] !== 1'b1 || log_rdy[ld2+1] !== 1'b0) begin
            nfail++; $display("FAIL bp_ready_window: %b%b%b want 010", log_rdy[ld2-1], log_rdy[ld2], log_rdy[ld2+1]);
        end
        for (int k = 0; k < exp_h.size(); k++) begin
            obs = seg_high(rise + k * BIT);
            nvec++; if (obs !== exp_h[k]) begin nfail++; $display("FAIL bp_bit%0d: high=%0d want %0d", k, obs, exp_h[k]); end
        end
        base = rise + exp_h.size() * BIT;
        nvec++; if (ones_in(base, RST) !== 0) begin nfail++; $display("FAIL bp_latch_low: ones=%0d want 0", ones_in(base, RST)); end
        fdi = find_pulse(1'b1, hs[0], base + RST + 40 - hs[0], fdc);
        nvec++; if (fdc !== 1 || fdi !== base + RST) begin nfail++; $display("FAIL bp_frame_done: at=%0d count=%0d want at=%0d count=1", fdi, fdc, base + RST); end
        void'(find_pulse(1'b0, hs[0], base + RST + 40 - hs[0], urc));
        nvec++; if (urc !== 0) begin nfail++; $display("FAIL bp_underrun: count=%0d want 0", urc); end
    endtask

    task automatic test_reset_midframe();
        logic [31:0] v;
        int hs, hs2, s, rise, base, fdi, fdc, obs;
        push(PW'($urandom), 1'b1, hs);
        push(PW'($urandom), 1'b1, hs2);
        while (cyc < hs + 1 + 510) @(negedge ACLK);
        #2;
        nvec++; if (dout !== 1'b1) begin nfail++; $display("FAIL mid_dout_before: got %b want 1", dout); end
        ARESETN = 1'b0;
        #1;
        nvec++; if (dout !== 1'b0)            begin nfail++; $display("FAIL mid_async_dout: got %b want 0", dout); end
        nvec++; if (bus.pixel_ready !== 1'b1) begin nfail++; $display("FAIL mid_async_ready: got %b want 1", bus.pixel_ready); end
        nvec++; if (busy !== 1'b0)            begin nfail++; $display("FAIL mid_async_busy: got %b want 0", busy); end
        repeat (3) @(negedge ACLK);
        ARESETN = 1'b1;
        #1;
        s = cyc;
        wait_cycles(30);
        nvec++; if (ones_in(s, 30) !== 0 || busy !== 1'b0) begin nfail++; $display("FAIL mid_discard: ones=%0d busy=%b want 0 0", ones_in(s, 30), busy); end
        v = 32'h0F0F_0F0F;
        pix_q = {};
        pix_q.push_back(v[PW-1:0]);
        model_bits();
        push(pix_q[0], 1'b1, hs);
        wait_cycles(PW * BIT + RST + 50);
        rise = find_rise(hs, 100);
        nvec++; if (rise !== hs + 1) begin nfail++; $display("FAIL mid_latency: rise=%0d want %0d", rise, hs + 1); end
        for (int k = 0; k < exp_h.size(); k++) begin
            obs = seg_high(rise + k * BIT);
            nvec++; if (obs !== exp_h[k]) begin nfail++; $display("FAIL mid_bit%0d: high=%0d want %0d", k, obs, exp_h[k]); end
        end
        base = rise + exp_h.size() * BIT;
        fdi = find_pulse(1'b1, hs, base + RST + 40 - hs, fdc);
        nvec++; if (fdc !== 1 || fdi !== base + RST) begin nfail++; $display("FAIL mid_frame_done: at=%0d count=%0d want at=%0d count=1", fdi, fdc, base + RST); end
    endtask

    initial begin
        bus.pixel_valid = 1'b0;
        bus.pixel_last  = 1'b0;
        bus.pixel_data  = '0;
        test_reset();
        test_single();
        test_back_to_back();
        test_underrun();
        test_backpressure();
        test_reset_midframe();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running at cycle %0d, want finished", cyc);
        $fatal(1, "watchdog expired");
    end
endmodule
